// File: rtl/if_icache_line.sv
// Instruction-fetch stage with a direct-mapped, multi-word-line instruction cache.
// Hits return combinationally; misses stall while a line-fill FSM fetches the line word by word.
module if_icache_line #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int INDEX_BITS = 6,
  parameter int OFF_BITS   = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [ADDR_W-1:0] _pc,
  output logic [INST_W-1:0] _instruction,
  output logic              stall_flag,
  output logic              _instruction_read_flag,
  output logic [ADDR_W-1:0] _instruction_read_address,
  input  logic              instruction_flag,
  input  logic [INST_W-1:0] instruction,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES   = 1 << INDEX_BITS;
  localparam int WORDS   = 1 << OFF_BITS;
  localparam int TAG_LSB = OFF_BITS + INDEX_BITS + 2;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_nxt;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [INST_W-1:0]     data_mem [LINES*WORDS];
  logic [ADDR_W-1:0]     base;
  logic [OFF_BITS-1:0]   cnt;
  logic                  flush_pending;

  logic [OFF_BITS-1:0]   off;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic [INDEX_BITS-1:0] base_idx;
  logic [TAG_W-1:0]      base_tag;
  logic                  hit;
  logic                  fill_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign off      = pc[OFF_BITS+1:2];
  assign idx      = pc[TAG_LSB-1:OFF_BITS+2];
  assign tag      = pc[ADDR_W-1:TAG_LSB];
  assign base_idx = base[TAG_LSB-1:OFF_BITS+2];
  assign base_tag = base[ADDR_W-1:TAG_LSB];

  assign hit       = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
  assign fill_done = (state == FILL) && instruction_flag && (&cnt);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!hit) state_nxt = FILL;
      FILL:    if (fill_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush seen at any point of a fill (including its last ack) keeps the
  // freshly filled line invalid and wipes every other line at completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid         <= '0;
      cnt           <= '0;
      miss_count    <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush)     valid      <= '0;
          else if (!hit) valid[idx] <= 1'b0;
          if (!hit) begin
            cnt        <= '0;
            miss_count <= sat_inc(miss_count);
          end
        end
        FILL: begin
          if (instruction_flag) cnt <= cnt + 1'b1;
          if (fill_done) begin
            if (flush_pending || flush) valid           <= '0;
            else                        valid[base_idx] <= 1'b1;
            flush_pending <= 1'b0;
          end else if (flush) begin
            flush_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && (state == IDLE) && !hit)
      base <= {pc[ADDR_W-1:OFF_BITS+2], {(OFF_BITS+2){1'b0}}};
    if (rst && (state == FILL) && instruction_flag) begin
      data_mem[{base_idx, cnt}] <= instruction;
      if (&cnt) tag_mem[base_idx] <= base_tag;
    end
  end

  always_comb begin
    _pc                       = '0;
    _instruction              = '0;
    stall_flag                = 1'b0;
    _instruction_read_flag    = 1'b0;
    _instruction_read_address = '0;
    if (rst) begin
      if (hit) begin
        _pc          = pc;
        _instruction = data_mem[{idx, off}];
      end else begin
        stall_flag = 1'b1;
        if (state == FILL) begin
          _instruction_read_flag    = 1'b1;
          _instruction_read_address = base + {{(ADDR_W-OFF_BITS-2){1'b0}}, cnt, 2'b00};
        end
      end
    end
  end

endmodule
